src_bus_arbiter: RTL and testbench
==================================

// Module: src_bus_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer owning the sel/srcoe controls of the registered source mux.
//  Requesters (default 0=A, 1=B, 2=INna, 3=outbuf) request the source bus.
//  The winner's code is driven onto sel; a release phase parks the bus at hi-Z (sel=0).
//  The block also emits a data-valid strobe that accounts for the mux's one-cycle register latency.
// PARAMETERS
//  NREQ      4   number of requesters, 1..7; requester i maps to sel code i+1
//  MAX_HOLD  16  max consecutive OWN cycles before forced release (SRC_ARB_TIMEOUT_EN only)
// PORTS
//  clk      in   1     system clock, rising edge
//  rst      in   1     reset, asynchronous, active-high
//  req      in   NREQ  per-requester bus request, level; must stay high while owning
//  rel      in   NREQ  per-requester release strobe; only the owner's bit is honoured
//  gnt      out  NREQ  one-hot grant, registered
//  sel      out  3     source-mux select: 0 = hi-Z/park, i+1 = requester i
//  srcoe    out  1     source-mux update enable
//  valid    out  1     bus carries the owner's data this cycle (srcoe & gnt delayed 1 cycle)
//  busy     out  1     state != IDLE
//  timeout  out  1     one-cycle pulse on forced release; tied 0 without the macro
// BEHAVIOUR
//  - Reset (async): state=IDLE; gnt=0, sel=0, srcoe=0, valid=0, busy=0, timeout=0.
//    - last-grant pointer ptr=NREQ-1, so requester 0 wins first.
//    - The mux register is not reset: the bus keeps its last value until the next srcoe.
//  - States:
//    - IDLE
//      - If |req: pick the first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
//      - Next edge: gnt=onehot(idx), sel=idx+1, srcoe=1; go to OWN.
//      - If req==0: stay; sel=0, srcoe=0.
//    - OWN
//      - Hold gnt, sel and srcoe=1.
//      - Release condition: rel[owner] OR !req[owner].
//      - On release, next edge: gnt=0, sel=0, srcoe=1, ptr=owner; go to REL.
//    - REL
//      - Exactly 1 cycle, so the mux latches hi-Z.
//      - Next edge: srcoe=0, sel=0; go to IDLE.
//  - Latency:
//    - req rising at edge N -> gnt/sel/srcoe at edge N+1 -> mux output and valid at edge N+2.
//    - valid falls 1 cycle after gnt falls.
//  - Turnaround: minimum gap from last OWN cycle to the next grant is 2 cycles (REL + IDLE).
//  - rel on non-owner bits is ignored in every state. rel with req low in IDLE is ignored.
//  - Simultaneous release of the owner and requests from others: the REL cycle is always taken first.
//    Next grant goes round-robin from the old owner.
//  - Owner drops req and asserts rel in the same cycle: treated as a single release.
//  - Reset mid-OWN/REL: outputs clear immediately, no clock needed; the bus is not parked.
//  - No combinational path from req/rel to any output; all outputs registered.
// CONFIGURATION
//  - SRC_ARB_TIMEOUT_EN defined:
//    - Hold counter, width $clog2(MAX_HOLD+1), clears on entry to OWN and increments each OWN cycle.
//    - When count==MAX_HOLD-1 and no release: force release, same transition as a normal release.
//    - timeout pulses high for the cycle in REL. ptr advances past the offender.
//  - Not defined: no counter; timeout tied 0; the owner holds indefinitely.
// STRUCTURE
//  - Package src_arb_pkg:
//    - state enum {IDLE, OWN, REL}
//    - SEL_PARK=3'h0, SEL_A=3'h1, SEL_B=3'h2, SEL_IN=3'h3, SEL_OUTBUF=3'h4
//    - function idx_to_sel
//  - Sub-module src_rr_pick (combinational): inputs req and ptr; outputs found and idx.
//    Rotate, priority-encode, unrotate.
// TESTING
//  1. Reset, then req=4'b0001 at edge 2:
//     - gnt=0001, sel=1, srcoe=1 after edge 3; valid=1 after edge 4.
//  2. req=4'b1111 held; each owner pulses rel after 3 OWN cycles:
//     - grant order 0,1,2,3,0; sel sequence 1,0,2,0,3,0,4,0,1.
//  3. Owner 0 drops req while req[2]=1:
//     - next cycle gnt=0, sel=0, srcoe=1 (REL); then IDLE; then gnt=0100, sel=3.
//  4. rel=4'b1000 while owner is 1:
//     - ignored; gnt stays 0010 and sel stays 2.
//  5. rst asserted between edges during OWN:
//     - gnt, sel, srcoe and valid read 0 before the next clk edge.
//     - After rst drops with req=0001, requester 0 is granted.
//  6. MAX_HOLD=4, owner never releases, req[1]=1:
//     - with SRC_ARB_TIMEOUT_EN: timeout pulse after 4 OWN cycles, then gnt=0010.
//     - without the macro: grant unchanged for 100 cycles; timeout stays 0.

Source files
------------

// File: rtl/src_arb_pkg.sv
// Shared types and constants for the source-bus arbiter.
// Sel codes match the registered source mux: 0 parks the bus at hi-Z,
// and requester i drives code i+1.
package src_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_PARK   = 3'h0;
    localparam logic [2:0] SEL_A      = 3'h1;
    localparam logic [2:0] SEL_B      = 3'h2;
    localparam logic [2:0] SEL_IN     = 3'h3;
    localparam logic [2:0] SEL_OUTBUF = 3'h4;

    // Requester index to mux select code (index 0 maps to SEL_A).
    function automatic logic [2:0] idx_to_sel(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/src_rr_pick.sv
// Combinational round-robin pick: finds the first set request bit
// scanning ptr+1, ptr+2, ... modulo NREQ. Implemented as rotate,
// priority-encode, unrotate.
module src_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic            found,
    output logic [2:0]      idx
);

    localparam logic [3:0] NREQ_W = 4'(NREQ);

    logic [2:0]        start_s;
    logic [2*NREQ-1:0] doubled_s;
    logic [2*NREQ-1:0] shifted_s;
    logic [NREQ-1:0]   rotated_s;
    logic [2:0]        enc_s;
    logic [3:0]        sum_s;

    // Scan starts one past the last winner, wrapping at NREQ.
    always_comb begin
        if (({1'b0, ptr} + 4'd1) >= NREQ_W) begin
            start_s = 3'd0;
        end else begin
            start_s = ptr + 3'd1;
        end
    end

    assign doubled_s = {req, req};
    assign shifted_s = doubled_s >> start_s;
    assign rotated_s = shifted_s[NREQ-1:0];

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        enc_s = 3'd0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated_s[k]) begin
                enc_s = 3'(k);
                found = 1'b1;
            end else begin
                enc_s = enc_s;
            end
        end
    end

    // Undo the rotation to recover the absolute requester index.
    always_comb begin
        sum_s = {1'b0, start_s} + {1'b0, enc_s};
        if (sum_s >= NREQ_W) begin
            idx = 3'(sum_s - NREQ_W);
        end else begin
            idx = sum_s[2:0];
        end
    end

endmodule

// File: rtl/src_bus_arbiter.sv
// Round-robin arbiter/sequencer for the registered source mux.
// Grants the bus, drives sel/srcoe, inserts a one-cycle park (REL)
// after every ownership so the mux latches hi-Z, and produces a
// data-valid strobe delayed for the mux register latency.
// Optional feature macro: SRC_ARB_TIMEOUT_EN (forced release after
// MAX_HOLD consecutive OWN cycles, flagged by a timeout pulse).
module src_bus_arbiter
    import src_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] rel,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      sel,
    output logic            srcoe,
    output logic            valid,
    output logic            busy,
    output logic            timeout
);

    localparam logic [2:0]      PTR_INIT = 3'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t     state_r;
    logic [2:0] ptr_r;
    logic [2:0] owner_r;

    logic       pick_found_s;
    logic [2:0] pick_idx_s;
    logic       user_release_s;
    logic       hold_expire_s;
    logic       release_s;

    src_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // gnt is one-hot while owning, so masking picks out the owner's bits.
    assign user_release_s = (|(gnt & rel)) | ~(|(gnt & req));
    assign release_s      = user_release_s | hold_expire_s;

`ifdef SRC_ARB_TIMEOUT_EN
    localparam int             CW        = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt_r;
    logic          timeout_r;

    assign hold_expire_s = (state_r == OWN) && (hold_cnt_r == HOLD_LAST);
    assign timeout       = timeout_r;

    // Count consecutive OWN cycles; flag a forced release for the REL cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            if (state_r == OWN) begin
                hold_cnt_r <= hold_cnt_r + CW'(1);
            end else begin
                hold_cnt_r <= '0;
            end
            timeout_r <= (state_r == OWN) & hold_expire_s & ~user_release_s;
        end
    end
`else
    assign hold_expire_s = 1'b0;
    assign timeout       = 1'b0;
`endif

    // Arbitration FSM with registered grant, select and enable outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            gnt     <= '0;
            sel     <= SEL_PARK;
            srcoe   <= 1'b0;
            busy    <= 1'b0;
            ptr_r   <= PTR_INIT;
            owner_r <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        state_r <= OWN;
                        gnt     <= ONE_HOT0 << pick_idx_s;
                        sel     <= idx_to_sel(pick_idx_s);
                        srcoe   <= 1'b1;
                        busy    <= 1'b1;
                        owner_r <= pick_idx_s;
                    end else begin
                        gnt   <= '0;
                        sel   <= SEL_PARK;
                        srcoe <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                OWN: begin
                    if (release_s) begin
                        state_r <= REL;
                        gnt     <= '0;
                        sel     <= SEL_PARK;
                        srcoe   <= 1'b1;
                        busy    <= 1'b1;
                        ptr_r   <= owner_r;
                    end else begin
                        srcoe <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                REL: begin
                    state_r <= IDLE;
                    gnt     <= '0;
                    sel     <= SEL_PARK;
                    srcoe   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    gnt     <= '0;
                    sel     <= SEL_PARK;
                    srcoe   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Mux output follows sel one cycle later, so valid lags the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else begin
            valid <= srcoe & (|gnt);
        end
    end

endmodule

// File: tb/tb_src_bus_arbiter.sv
// Self-checking bench for src_bus_arbiter: directed scenarios plus
// randomized traffic, with a cycle-level reference model feeding an
// expected-output queue and a grant-order queue checked by a monitor.
module tb_src_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;
`ifdef SRC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rel;
    logic [NREQ-1:0] gnt;
    logic [2:0]      sel;
    logic            srcoe;
    logic            valid;
    logic            busy;
    logic            timeout;

    always #5 clk = ~clk;

    src_bus_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .sel     (sel),
        .srcoe   (srcoe),
        .valid   (valid),
        .busy    (busy),
        .timeout (timeout)
    );

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [2:0]      sel;
        logic            srcoe;
        logic            valid;
        logic            busy;
        logic            timeout;
    } obs_t;

    obs_t exp_q[$];
    int   grant_q[$];
    int   seen_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   to_pulses = 0;

    // Reference model: who owns the bus, whether the park cycle is due,
    // the last winner, and how long the owner has held.
    int   m_owner;
    bit   m_parking;
    int   m_last;
    int   m_hold;
    int   m_grants;
    obs_t m_out;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_obs(input obs_t e);
        check("gnt",     int'(gnt),     int'(e.gnt));
        check("sel",     int'(sel),     int'(e.sel));
        check("srcoe",   int'(srcoe),   int'(e.srcoe));
        check("valid",   int'(valid),   int'(e.valid));
        check("busy",    int'(busy),    int'(e.busy));
        check("timeout", int'(timeout), int'(e.timeout));
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_parking = 1'b0;
        m_last    = NREQ - 1;
        m_hold    = 0;
        m_out     = '0;
    endtask

    // Outputs after the next clock edge, given the inputs of this cycle.
    task automatic model_step(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] rl);
        obs_t n;
        bit   drop;
        bit   forced;
        int   c;
        n       = '0;
        n.valid = m_out.srcoe && (m_out.gnt != '0);
        if (m_owner >= 0) begin
            drop   = rl[m_owner] || !rq[m_owner];
            forced = TO_EN && !drop && (m_hold == MAX_HOLD - 1);
            if (drop || forced) begin
                m_last    = m_owner;
                m_owner   = -1;
                m_parking = 1'b1;
                n.srcoe   = 1'b1;
                n.busy    = 1'b1;
                n.timeout = forced;
            end else begin
                m_hold++;
                n.gnt   = NREQ'(1) << m_owner;
                n.sel   = 3'(m_owner + 1);
                n.srcoe = 1'b1;
                n.busy  = 1'b1;
            end
        end else if (m_parking) begin
            m_parking = 1'b0;
        end else if (rq != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (rq[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_hold = 0;
            m_grants++;
            n.gnt   = NREQ'(1) << m_owner;
            n.sel   = 3'(m_owner + 1);
            n.srcoe = 1'b1;
            n.busy  = 1'b1;
            grant_q.push_back(m_owner);
        end
        m_out = n;
        exp_q.push_back(n);
    endtask

    // One stimulus cycle: drive just after the falling edge, predict the next edge.
    task automatic do_cycle(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] rl);
        @(negedge clk);
        #1;
        rst = r;
        req = rq;
        rel = rl;
        if (r) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_step(rq, rl);
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, '0, '0);
    endtask

    // Monitor: compares every presented cycle and the order of new grants.
    initial begin : monitor
        obs_t            e;
        logic [NREQ-1:0] prev_gnt;
        int              ei;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_obs(e);
            end
            if (gnt != '0 && prev_gnt == '0) begin
                seen_q.push_back(oh_idx(gnt));
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", oh_idx(gnt), -1);
                end else begin
                    ei = grant_q.pop_front();
                    check("grant_order", oh_idx(gnt), ei);
                end
            end
            if (timeout) to_pulses++;
            prev_gnt = gnt;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [NREQ-1:0] rq;
        logic [NREQ-1:0] rl;
        int              rl_hold;

        rst = 1'b1;
        req = '0;
        rel = '0;
        model_reset();
        m_grants = 0;

        // Test 1: reset state, then single requester latency.
        reset_cycles(3);
        do_cycle(1'b0, 4'b0000, '0);
        do_cycle(1'b0, 4'b0001, '0);
        do_cycle(1'b0, 4'b0001, '0);
        check("t1_gnt", int'(gnt), 1);
        check("t1_sel", int'(sel), 1);
        check("t1_valid_early", int'(valid), 0);
        do_cycle(1'b0, 4'b0001, '0);
        check("t1_valid", int'(valid), 1);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'b0000, '0);

        // Test 2: all request, each owner releases after 3 OWN cycles.
        reset_cycles(2);
        seen_q.delete();
        m_grants = 0;
        for (int c = 0; c < 80 && !(m_grants >= 5 && m_owner < 0); c++) begin
            rl = '0;
            if (m_owner >= 0 && m_hold == 3) rl = NREQ'(1) << m_owner;
            if (m_owner == 1 && m_hold == 1) rl = 4'b1000;
            do_cycle(1'b0, 4'b1111, rl);
        end
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 4'b0000, '0);
        check("t2_grants", seen_q.size(), 5);
        for (int i = 0; i < 5 && i < seen_q.size(); i++) check("t2_order", seen_q[i], i % NREQ);

        // Test 3: owner 0 drops req while requester 2 waits.
        reset_cycles(2);
        seen_q.delete();
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'b0101, '0);
        do_cycle(1'b0, 4'b0100, '0);
        do_cycle(1'b0, 4'b0100, '0);
        check("t3_rel_gnt", int'(gnt), 0);
        check("t3_rel_srcoe", int'(srcoe), 1);
        do_cycle(1'b0, 4'b0100, '0);
        do_cycle(1'b0, 4'b0100, '0);
        check("t3_gnt2", int'(gnt), 4);
        check("t3_sel3", int'(sel), 3);

        // Test 4: release strobe on a non-owner bit is ignored.
        reset_cycles(2);
        for (int i = 0; i < 2; i++) do_cycle(1'b0, 4'b0010, '0);
        do_cycle(1'b0, 4'b0010, 4'b1000);
        do_cycle(1'b0, 4'b0010, '0);
        check("t4_gnt", int'(gnt), 2);
        check("t4_sel", int'(sel), 2);

        // Test 5: asynchronous reset while owning.
        reset_cycles(2);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'b0001, '0);
        do_cycle(1'b1, 4'b0001, '0);
        #1;
        check("t5_async_gnt", int'(gnt), 0);
        check("t5_async_sel", int'(sel), 0);
        check("t5_async_srcoe", int'(srcoe), 0);
        check("t5_async_valid", int'(valid), 0);
        do_cycle(1'b1, 4'b0001, '0);
        seen_q.delete();
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'b0001, '0);
        check("t5_regrant_cnt", seen_q.size(), 1);
        if (seen_q.size() > 0) check("t5_regrant", seen_q[0], 0);

        // Test 6: owner never releases while requester 1 waits.
        reset_cycles(2);
        seen_q.delete();
        to_pulses = 0;
        for (int i = 0; i < 100; i++) do_cycle(1'b0, 4'b0011, '0);
        if (TO_EN) begin
            check("t6_timeout_seen", int'(to_pulses > 0), 1);
            check("t6_second_owner", (seen_q.size() > 1) ? seen_q[1] : -1, 1);
        end else begin
            check("t6_timeout_none", to_pulses, 0);
            check("t6_single_grant", seen_q.size(), 1);
        end

        // Randomized traffic with sticky requests and sparse release strobes.
        reset_cycles(2);
        rq = '0;
        rl_hold = 0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            end
            rl = '0;
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 7) == 0) rl[b] = 1'b1;
            end
            rl_hold = int'($urandom_range(0, 199));
            do_cycle(rl_hold == 0, rq, rl);
        end

        do_cycle(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("grant_queue_drained", grant_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
